mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, meaning maximum consecutive grants to one requester when MUX_ARB_BURST_EN is defined (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port req, input, 8, per-requester request; bit i high means data[i] is valid.
REQ-005 SHALL have port data, input, 8 x 8 unpacked array [0:7], per-requester payload; held stable while req[i] is high.
REQ-006 SHALL have port ack, output, 8, one-hot single-cycle acknowledge; ack[i] marks data[i] as captured this cycle.
REQ-007 SHALL have port out_valid, output, 1, the output register holds a transfer.
REQ-008 SHALL have port out_ready, input, 1, the consumer accepts the transfer when it is high together with out_valid.
REQ-009 SHALL have port out_data, output, 8, captured payload.
REQ-010 SHALL have port out_sel, output, 3, index of the requester that sourced out_data.

Function
REQ-011 SHALL treat the output register as free when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-012 SHALL, in any cycle the register is free and req!=0, pick a winner round-robin: the first set req bit at or after index ptr, wrapping 7->0.
REQ-013 SHALL in that cycle assert ack[winner], and on the next edge load out_data=data[winner], out_sel=winner, out_valid=1 (1-cycle latency, req to out_valid).
REQ-014 SHALL advance ptr to (winner+1) mod 8 on each grant; ptr SHALL be unchanged in cycles without a grant.
REQ-015 SHALL clear out_valid when the register is free and req==0; out_data and out_sel SHALL hold their last values.
REQ-016 SHALL keep ack=0 whenever the register is not free (out_valid=1, out_ready=0); out_data, out_sel and ptr SHALL then be held.
REQ-017 SHALL support back-to-back transfers: with out_ready held at 1 and requests pending, one grant per cycle.
REQ-018 SHALL have state machine IDLE (out_valid=0) and FULL (out_valid=1), with these transitions:
- IDLE->FULL on a grant.
- FULL->FULL on a grant or a stall.
- FULL->IDLE when out_ready=1 and req==0.
REQ-019 SHALL ignore req bits that drop without ack; no request is latched internally.
REQ-020 SHALL never assert more than one ack bit in a cycle.

Reset
REQ-021 SHALL, with rst high at a clock edge, set state=IDLE, out_valid=0, out_data=0, out_sel=0, ptr=0, burst count=0.
REQ-022 SHALL hold ack=0 in any cycle rst is high; a transfer in flight when reset is asserted SHALL be discarded.

Configuration
REQ-023 SHALL support macro MUX_ARB_BURST_EN.
- Defined: after a grant to i, if req[i] is still high and the consecutive-grant count is below BURST_MAX, the next grant SHALL go to i again, with ptr held at i. The count resets when the winner changes.
- Undefined: pure round-robin per REQ-012/014, and no burst counter is instantiated.

Structure
REQ-024 SHALL take NUM_REQ=8, SEL_W=3, DATA_W=8 and the state enum typedef (IDLE, FULL) from package mux_arb_pkg.
REQ-025 SHALL place the combinational rotate-and-priority-find in sub-module mux_rr_pick (inputs req, ptr; outputs found, idx).

Verification
REQ-026 SHALL verify: reset, then req=8'hFF with out_ready=1 -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles, each with a matching ack pulse.
REQ-027 SHALL verify: req=8'h81 with ptr=1 -> first grant idx 7, then idx 0, then idx 7.
REQ-028 SHALL verify: out_valid=1, out_ready=0 for 3 cycles, req=8'h04 -> ack=0 and out_data stable; on out_ready=1, ack[2] fires the same cycle.
REQ-029 SHALL verify: single req[5] with data[5]=8'hA5 -> out_valid next cycle, out_data=8'hA5, out_sel=5; req dropped, out_ready=1 -> out_valid=0.
REQ-030 SHALL verify: rst asserted while out_valid=1 -> next cycle out_valid=0, out_data=0, and the next grant starts search at index 0.
REQ-031 SHALL verify, with MUX_ARB_BURST_EN and BURST_MAX=2, req=8'h03 -> grant order 0,0,1,1,0,0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared sizes and FSM state type for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int DATA_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating priority finder: returns the first set request at or after ptr,
// wrapping from the top index back to 0.
module mux_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] pos;

    // Scan offsets from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin 8:1 arbiter with a single registered output slot.
// Optional macro MUX_ARB_BURST_EN lets one requester keep the grant for up to
// BURST_MAX consecutive transfers while it keeps requesting.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  data [0:NUM_REQ-1],
    output logic [NUM_REQ-1:0] ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_sel
);

    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
        $error("BURST_MAX must be in 1..15");
    end

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;

    logic             free;
    logic             found;
    logic             grant;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] winner;

    mux_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    // The slot can take a new transfer when empty or being drained this cycle.
    assign free  = (state_q == IDLE) || out_ready;
    assign grant = free && found && !rst;

`ifdef MUX_ARB_BURST_EN
    logic [3:0]       cnt_q;
    logic [SEL_W-1:0] last_q;
    logic             burst_hit;

    // Previous winner keeps the grant while it still requests and its run is short.
    assign burst_hit = (cnt_q != 4'd0) && (cnt_q < 4'(BURST_MAX)) && req[last_q];
    assign winner    = burst_hit ? last_q : pick_idx;

    // Track the current winner and the length of its consecutive-grant run.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 4'd0;
            last_q <= '0;
        end else if (grant) begin
            cnt_q  <= burst_hit ? cnt_q + 4'd1 : 4'd1;
            last_q <= winner;
        end
    end
`else
    assign winner = pick_idx;
`endif

    // Next search starts just past the winner, wrapping naturally in SEL_W bits.
    assign ptr_d = winner + SEL_W'(1);

    // One-hot acknowledge for the requester captured this cycle.
    always_comb begin
        ack = '0;
        if (grant) begin
            ack[winner] = 1'b1;
        end
    end

    // Output slot FSM: IDLE is empty, FULL holds a transfer for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_sel_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q    <= FULL;
                        ptr_q      <= ptr_d;
                        out_data_q <= data[winner];
                        out_sel_q  <= winner;
                    end
                end
                FULL: begin
                    if (grant) begin
                        ptr_q      <= ptr_d;
                        out_data_q <= data[winner];
                        out_sel_q  <= winner;
                    end else if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a cycle-level reference model checked
// every cycle, plus directed sequences with literal expectations.
module tb_mux_rr_arbiter;

`ifdef MUX_ARB_BURST_EN
    localparam int BM = 2;
`else
    localparam int BM = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] data [0:7];
    logic [7:0] ack;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [2:0] out_sel;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.BURST_MAX(BM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model state
    bit         armed = 1'b0;
    int         m_ptr = 0;
    int         m_last = 0;
    int         m_cnt = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_sel = 0;

    // Returns the requester that must be acknowledged this cycle, or -1.
    function automatic int m_winner();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        if (req == 8'h00) return -1;
`ifdef MUX_ARB_BURST_EN
        if (m_cnt >= 1 && m_cnt < BM && req[m_last]) return m_last;
`endif
        for (int k = 0; k < 8; k++) begin
            if (req[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model_update
        int w;
        w = m_winner();
        if (rst) begin
            armed   = 1'b1;
            m_ptr   = 0;
            m_last  = 0;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_sel   = 0;
        end else if (w >= 0) begin
            m_cnt   = (w == m_last && m_cnt >= 1 && m_cnt < BM) ? m_cnt + 1 : 1;
            m_last  = w;
            m_valid = 1'b1;
            m_data  = data[w];
            m_sel   = w;
            m_ptr   = (w + 1) % 8;
        end else if (!m_valid || out_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin : model_compare
        int w;
        if (armed) begin
            w = m_winner();
            chk("model_ack", ack, (w >= 0) ? (32'd1 << w) : 32'd0);
            chk("model_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("model_out_data", out_data, m_data);
                chk("model_out_sel", out_sel, m_sel);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [7:0] burst_exp [0:5];

    initial begin
        for (int i = 0; i < 8; i++) data[i] = 8'(8'h10 + i);

        rst = 1'b1; req = 8'h00; out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        neg();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        cyc();

`ifdef MUX_ARB_BURST_EN
        burst_exp[0] = 8'h01; burst_exp[1] = 8'h01; burst_exp[2] = 8'h02;
        burst_exp[3] = 8'h02; burst_exp[4] = 8'h01; burst_exp[5] = 8'h01;
        req = 8'h03;
        for (int k = 0; k < 6; k++) begin
            neg();
            chk("burst_ack", ack, burst_exp[k]);
            cyc();
        end
        req = 8'h00;
        cyc(); cyc();
`else
        // Full request vector rotates through every requester
        req = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            neg();
            chk("rr_ack", ack, 32'd1 << (k % 8));
            if (k > 0) chk("rr_sel", out_sel, (k - 1) % 8);
            cyc();
        end
        req = 8'h00;
        neg();
        chk("rr_sel_last", out_sel, 1);
        chk("rr_idle_ack", ack, 0);
        cyc(); cyc();

        // Wrap case with pointer at 1
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 8'h01;
        neg(); chk("wrap_setup_ack", ack, 8'h01); cyc();
        req = 8'h81;
        neg(); chk("wrap_ack0", ack, 8'h80); cyc();
        neg(); chk("wrap_ack1", ack, 8'h01); cyc();
        neg(); chk("wrap_ack2", ack, 8'h80); cyc();
        req = 8'h00;
        cyc(); cyc();

        // Backpressure stall
        data[2] = 8'h33; req = 8'h04; out_ready = 1'b0;
        neg(); chk("stall_first_ack", ack, 8'h04); cyc();
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("stall_ack", ack, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 8'h33);
            cyc();
        end
        out_ready = 1'b1;
        neg(); chk("stall_release_ack", ack, 8'h04); cyc();
        req = 8'h00;
        cyc(); cyc();

        // Single request, then drain
        data[5] = 8'hA5; req = 8'h20;
        neg(); chk("single_ack", ack, 8'h20); cyc();
        req = 8'h00;
        neg();
        chk("single_out_valid", out_valid, 1);
        chk("single_out_data", out_data, 8'hA5);
        chk("single_out_sel", out_sel, 5);
        cyc();
        neg();
        chk("drain_out_valid", out_valid, 0);
        chk("drain_out_data_held", out_data, 8'hA5);
        cyc();

        // Reset with a transfer in flight
        req = 8'hFF; out_ready = 1'b0;
        neg(); chk("pre_rst_ack", ack, 8'h40); cyc();
        rst = 1'b1;
        neg();
        chk("in_rst_ack", ack, 0);
        chk("in_rst_out_valid", out_valid, 1);
        cyc();
        rst = 1'b0; req = 8'h00;
        neg();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_data", out_data, 0);
        cyc();
        req = 8'hFF; out_ready = 1'b1;
        neg(); chk("post_rst_ack", ack, 8'h01); cyc();
        req = 8'h00;
        cyc(); cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
